// File: rtl/divider_pkg.sv
// Shared definitions for the restoring divider: FSM state encoding and
// the width helper for the iteration counter.
package divider_pkg;

   typedef enum logic [2:0] {
      SLEEP      = 3'd0,
      LOAD_DATA  = 3'd1,
      SHIFT      = 3'd2,
      SUBTRACT   = 3'd3,
      RESTORE    = 3'd4,
      CHECK_ZERO = 3'd5,
      READY      = 3'd6
   } state_t;

   // The counter must hold the value WIDTH itself, hence WIDTH+1.
   function automatic int cnt_width(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/divider_controller.sv
// Sequencing FSM for the restoring divider. Datapath strobes are registered
// from the next state, so each one is high during the state it names.
module divider_controller
   import divider_pkg::*;
(
   input  logic   Clock,
   input  logic   Reset,
   input  logic   Start,
   input  logic   A_Neg,
   input  logic   Zero,
   input  logic   Div0,
   output logic   Load_regs,
   output logic   Shift_regs,
   output logic   Sub_regs,
   output logic   Restore_regs,
   output logic   Check_regs,
   output logic   Add_back,
   output logic   Decr_P,
   output logic   Ready,
   output logic   Busy,
   output state_t State
);

   state_t state;
   state_t next_state;

   always_comb begin
      next_state = SLEEP;
      case (state)
         SLEEP:      next_state = Start ? LOAD_DATA : SLEEP;
         LOAD_DATA:  next_state = Div0 ? READY : SHIFT;
         SHIFT:      next_state = SUBTRACT;
         SUBTRACT:   next_state = RESTORE;
         RESTORE:    next_state = CHECK_ZERO;
         CHECK_ZERO: next_state = Zero ? READY : SHIFT;
         READY:      next_state = SLEEP;
         default:    next_state = SLEEP;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (!Reset) begin
         state        <= SLEEP;
         Load_regs    <= 1'b0;
         Shift_regs   <= 1'b0;
         Sub_regs     <= 1'b0;
         Restore_regs <= 1'b0;
         Check_regs   <= 1'b0;
         Decr_P       <= 1'b0;
         Ready        <= 1'b0;
         Busy         <= 1'b0;
      end else begin
         state        <= next_state;
         Load_regs    <= (next_state == LOAD_DATA);
         Shift_regs   <= (next_state == SHIFT);
         Sub_regs     <= (next_state == SUBTRACT);
         Restore_regs <= (next_state == RESTORE);
         Check_regs   <= (next_state == CHECK_ZERO);
         Decr_P       <= (next_state == RESTORE);
         Ready        <= (next_state == READY);
         Busy         <= (next_state != SLEEP) && (next_state != READY);
      end
   end

   // The sign of the trial subtraction is only known inside RESTORE.
   assign Add_back = Restore_regs & A_Neg;
   assign State    = state;

endmodule

// File: rtl/restoring_divider.sv
// Sequential unsigned restoring divider: one quotient bit per
// shift/subtract/restore/check round, WIDTH rounds per operation.
module restoring_divider
   import divider_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             Start,
   input  logic [WIDTH-1:0] Dividend,
   input  logic [WIDTH-1:0] Divisor,
   output logic [WIDTH-1:0] Quotient,
   output logic [WIDTH-1:0] Remainder,
   output logic             Ready,
   output logic             Busy,
   output logic             Div_By_Zero
);

   localparam int PW = cnt_width(WIDTH);

   logic [WIDTH:0]   a;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] m;
   logic [PW-1:0]    p;

   logic   load_regs, shift_regs, sub_regs, restore_regs, check_regs;
   logic   add_back, decr_p;
   logic   zero, div0;
   state_t state;

   assign zero = (p == '0);
   assign div0 = (Divisor == '0);

   divider_controller u_ctrl (
      .Clock        (Clock),
      .Reset        (Reset),
      .Start        (Start),
      .A_Neg        (a[WIDTH]),
      .Zero         (zero),
      .Div0         (div0),
      .Load_regs    (load_regs),
      .Shift_regs   (shift_regs),
      .Sub_regs     (sub_regs),
      .Restore_regs (restore_regs),
      .Check_regs   (check_regs),
      .Add_back     (add_back),
      .Decr_P       (decr_p),
      .Ready        (Ready),
      .Busy         (Busy),
      .State        (state)
   );

   always_ff @(posedge Clock) begin
      if (!Reset) begin
         a           <= '0;
         q           <= '0;
         m           <= '0;
         p           <= '0;
         Quotient    <= '0;
         Remainder   <= '0;
         Div_By_Zero <= 1'b0;
      end else begin
         if (load_regs) begin
            a <= '0;
            q <= Dividend;
            m <= Divisor;
            p <= PW'(WIDTH);
            if (div0) begin
               Quotient    <= '1;
               Remainder   <= Dividend;
               Div_By_Zero <= 1'b1;
            end else begin
               Div_By_Zero <= 1'b0;
            end
         end
         if (shift_regs)
            {a, q} <= {a[WIDTH-1:0], q, 1'b0};
         if (sub_regs)
            a <= a - {1'b0, m};
         // A negative trial difference means the divisor did not fit: undo it.
         if (restore_regs) begin
            if (add_back)
               a <= a + {1'b0, m};
            q[0] <= ~add_back;
         end
         if (decr_p)
            p <= p - PW'(1);
         if (check_regs && zero) begin
            Quotient  <= q;
            Remainder <= a[WIDTH-1:0];
         end
      end
   end

   // Current state is visible to checkers through u_ctrl.State.
   logic unused_state;
   assign unused_state = ^state;

endmodule

// File: tb/tb_restoring_divider.sv
// Directed and randomized checks of the restoring divider at WIDTH=8 and WIDTH=5.
module tb_restoring_divider;
   import divider_pkg::*;

   logic       Clock;
   logic       Reset;
   logic       Start;
   logic [7:0] Dividend, Divisor, Quotient, Remainder;
   logic       Ready, Busy, Div_By_Zero;

   logic       start_5;
   logic [4:0] dividend_5, divisor_5, quotient_5, remainder_5;
   logic       ready_5, busy_5, dbz_5;

   int checks = 0;
   int errors = 0;

   restoring_divider #(.WIDTH(8)) dut8 (
      .Clock(Clock), .Reset(Reset), .Start(Start),
      .Dividend(Dividend), .Divisor(Divisor),
      .Quotient(Quotient), .Remainder(Remainder),
      .Ready(Ready), .Busy(Busy), .Div_By_Zero(Div_By_Zero)
   );

   restoring_divider #(.WIDTH(5)) dut5 (
      .Clock(Clock), .Reset(Reset), .Start(start_5),
      .Dividend(dividend_5), .Divisor(divisor_5),
      .Quotient(quotient_5), .Remainder(remainder_5),
      .Ready(ready_5), .Busy(busy_5), .Div_By_Zero(dbz_5)
   );

   // clock / reset
   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   // driver: one 8-bit operation, observed from cycle 0 (SLEEP with Start=1)
   task automatic do_op8(input logic [7:0] dd, input logic [7:0] dv, input bit toggle,
                         output int rdy_cyc, output int pulses,
                         output int b_first, output int b_last,
                         output logic [7:0] oq, output logic [7:0] orem,
                         output logic odz, output bit dz_any);
      rdy_cyc = -1; pulses = 0; b_first = -1; b_last = -1;
      oq = 'x; orem = 'x; odz = 1'bx; dz_any = 0;
      @(posedge Clock); #1;
      Start = 1'b1; Dividend = dd; Divisor = dv;
      for (int cyc = 0; cyc <= 36; cyc++) begin
         if (cyc > 0) begin @(posedge Clock); #1; end
         if (cyc == 1) Start = 1'b0;
         if (cyc == 2) begin Dividend = ~dd; Divisor = dv ^ 8'h5a; end
         if (toggle && cyc >= 2 && cyc <= 30) Start = 1'($urandom_range(0, 1));
         if (cyc == 31) Start = 1'b0;
         if (Busy) begin
            if (b_first < 0) b_first = cyc;
            b_last = cyc;
         end
         if (Ready) begin
            pulses++;
            if (rdy_cyc < 0) begin
               rdy_cyc = cyc; oq = Quotient; orem = Remainder; odz = Div_By_Zero;
            end
         end
         if (cyc >= 2 && Div_By_Zero) dz_any = 1;
      end
   endtask

   task automatic test_reset();
      Reset = 1'b0; Start = 1'b0; Dividend = '0; Divisor = '0;
      start_5 = 1'b0; dividend_5 = '0; divisor_5 = '0;
      repeat (3) @(posedge Clock);
      #1;
      checks++; if (Quotient !== 8'd0) begin errors++; $display("FAIL reset_quotient got %0d want 0", Quotient); end
      checks++; if (Remainder !== 8'd0) begin errors++; $display("FAIL reset_remainder got %0d want 0", Remainder); end
      checks++; if (Ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", Ready); end
      checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", Busy); end
      checks++; if (Div_By_Zero !== 1'b0) begin errors++; $display("FAIL reset_dbz got %b want 0", Div_By_Zero); end
      checks++; if (dut8.u_ctrl.State !== SLEEP) begin errors++; $display("FAIL reset_state got %0d want 0", dut8.u_ctrl.State); end
      Reset = 1'b1;
   endtask

   task automatic test_basic();
      logic [7:0] t_dd [5] = '{8'd100, 8'd255, 8'd5, 8'd200, 8'd1};
      logic [7:0] t_dv [5] = '{8'd7,   8'd1,   8'd9, 8'd200, 8'd255};
      logic [7:0] t_q  [5] = '{8'd14,  8'd255, 8'd0, 8'd1,   8'd0};
      logic [7:0] t_r  [5] = '{8'd2,   8'd0,   8'd5, 8'd0,   8'd1};
      int rc, pc, bf, bl; logic [7:0] gq, gr; logic gdz; bit dza;
      for (int i = 0; i < 5; i++) begin
         do_op8(t_dd[i], t_dv[i], 0, rc, pc, bf, bl, gq, gr, gdz, dza);
         checks++; if (rc !== 34) begin errors++; $display("FAIL basic%0d_ready_cycle got %0d want 34", i, rc); end
         checks++; if (pc !== 1) begin errors++; $display("FAIL basic%0d_ready_pulses got %0d want 1", i, pc); end
         checks++; if (bf !== 1 || bl !== 33) begin errors++; $display("FAIL basic%0d_busy_window got %0d..%0d want 1..33", i, bf, bl); end
         checks++; if (gq !== t_q[i]) begin errors++; $display("FAIL basic%0d_quotient got %0d want %0d", i, gq, t_q[i]); end
         checks++; if (gr !== t_r[i]) begin errors++; $display("FAIL basic%0d_remainder got %0d want %0d", i, gr, t_r[i]); end
         checks++; if (gdz !== 1'b0 || dza) begin errors++; $display("FAIL basic%0d_dbz got %b/%0d want 0/0", i, gdz, dza); end
      end
   endtask

   task automatic test_div_zero();
      int rc, pc, bf, bl; logic [7:0] gq, gr; logic gdz; bit dza;
      do_op8(8'd37, 8'd0, 0, rc, pc, bf, bl, gq, gr, gdz, dza);
      checks++; if (rc !== 2) begin errors++; $display("FAIL dz_ready_cycle got %0d want 2", rc); end
      checks++; if (pc !== 1) begin errors++; $display("FAIL dz_ready_pulses got %0d want 1", pc); end
      checks++; if (bf !== 1 || bl !== 1) begin errors++; $display("FAIL dz_busy_window got %0d..%0d want 1..1", bf, bl); end
      checks++; if (gq !== 8'd255) begin errors++; $display("FAIL dz_quotient got %0d want 255", gq); end
      checks++; if (gr !== 8'd37) begin errors++; $display("FAIL dz_remainder got %0d want 37", gr); end
      checks++; if (gdz !== 1'b1 || !dza) begin errors++; $display("FAIL dz_flag got %b held %0d want 1 held 1", gdz, dza); end
      do_op8(8'd9, 8'd3, 0, rc, pc, bf, bl, gq, gr, gdz, dza);
      checks++; if (rc !== 34 || pc !== 1) begin errors++; $display("FAIL dz_next_ready got cycle %0d pulses %0d want 34/1", rc, pc); end
      checks++; if (gq !== 8'd3 || gr !== 8'd0) begin errors++; $display("FAIL dz_next_result got %0d,%0d want 3,0", gq, gr); end
      checks++; if (gdz !== 1'b0 || dza) begin errors++; $display("FAIL dz_next_cleared got %b/%0d want 0/0", gdz, dza); end
   endtask

   task automatic test_reset_mid();
      int pulses = 0;
      @(posedge Clock); #1;
      Start = 1'b1; Dividend = 8'd100; Divisor = 8'd7;
      for (int cyc = 1; cyc <= 15; cyc++) begin
         @(posedge Clock); #1;
         if (cyc == 1) Start = 1'b0;
         if (Ready) pulses++;
      end
      Reset = 1'b0;
      @(posedge Clock); #1;
      Reset = 1'b1;
      checks++; if (Quotient !== 8'd0 || Remainder !== 8'd0) begin errors++; $display("FAIL midreset_result got %0d,%0d want 0,0", Quotient, Remainder); end
      checks++; if (Ready !== 1'b0 || Busy !== 1'b0 || Div_By_Zero !== 1'b0) begin errors++; $display("FAIL midreset_flags got rdy %b busy %b dbz %b want 0 0 0", Ready, Busy, Div_By_Zero); end
      checks++; if (dut8.u_ctrl.State !== SLEEP) begin errors++; $display("FAIL midreset_state got %0d want 0", dut8.u_ctrl.State); end
      for (int cyc = 0; cyc < 30; cyc++) begin
         @(posedge Clock); #1;
         if (Ready) pulses++;
      end
      checks++; if (pulses !== 0) begin errors++; $display("FAIL midreset_no_ready got %0d pulses want 0", pulses); end
   endtask

   task automatic test_start_toggle();
      int rc, pc, bf, bl; logic [7:0] gq, gr; logic gdz; bit dza;
      do_op8(8'd100, 8'd7, 1, rc, pc, bf, bl, gq, gr, gdz, dza);
      checks++; if (rc !== 34 || pc !== 1) begin errors++; $display("FAIL toggle_ready got cycle %0d pulses %0d want 34/1", rc, pc); end
      checks++; if (gq !== 8'd14 || gr !== 8'd2) begin errors++; $display("FAIL toggle_result got %0d,%0d want 14,2", gq, gr); end
   endtask

   task automatic test_back_to_back();
      int rcyc [$];
      logic [7:0] rq [$];
      logic [7:0] rr [$];
      @(posedge Clock); #1;
      Start = 1'b1; Dividend = 8'd50; Divisor = 8'd6;
      for (int cyc = 0; cyc <= 80; cyc++) begin
         if (cyc > 0) begin @(posedge Clock); #1; end
         if (cyc == 80) Start = 1'b0;
         if (Ready) begin rcyc.push_back(cyc); rq.push_back(Quotient); rr.push_back(Remainder); end
      end
      checks++;
      if (rcyc.size() !== 2) begin
         errors++; $display("FAIL b2b_completions got %0d want 2", rcyc.size());
      end else begin
         checks++; if (rcyc[0] !== 34 || rcyc[1] !== 69) begin errors++; $display("FAIL b2b_ready_cycles got %0d,%0d want 34,69", rcyc[0], rcyc[1]); end
         checks++; if (rq[0] !== 8'd8 || rr[0] !== 8'd2 || rq[1] !== 8'd8 || rr[1] !== 8'd2) begin
            errors++; $display("FAIL b2b_results got %0d,%0d and %0d,%0d want 8,2 twice", rq[0], rr[0], rq[1], rr[1]);
         end
      end
      repeat (40) @(posedge Clock);
   endtask

   task automatic test_random8(input int n);
      int rc, pc, bf, bl; logic [7:0] gq, gr; logic gdz; bit dza;
      int dd, dv;
      for (int i = 0; i < n; i++) begin
         dd = $urandom_range(0, 255);
         dv = $urandom_range(1, 255);
         do_op8(8'(dd), 8'(dv), 0, rc, pc, bf, bl, gq, gr, gdz, dza);
         checks++;
         if (pc !== 1 || int'(gq) * dv + int'(gr) != dd || int'(gr) >= dv || int'(gq) != dd / dv || gdz !== 1'b0) begin
            errors++; $display("FAIL rand8 %0d/%0d got q %0d r %0d pulses %0d want q %0d r %0d", dd, dv, gq, gr, pc, dd / dv, dd % dv);
         end
      end
   endtask

   task automatic test_random5(input int n);
      int dd, dv, pulses;
      logic [4:0] gq, gr;
      for (int i = 0; i < n; i++) begin
         dd = $urandom_range(0, 31);
         dv = $urandom_range(1, 31);
         pulses = 0; gq = 'x; gr = 'x;
         @(posedge Clock); #1;
         start_5 = 1'b1; dividend_5 = 5'(dd); divisor_5 = 5'(dv);
         for (int cyc = 1; cyc <= 24; cyc++) begin
            @(posedge Clock); #1;
            if (cyc == 1) start_5 = 1'b0;
            if (ready_5) begin
               pulses++; gq = quotient_5; gr = remainder_5;
               if (cyc != 22) pulses += 100;
            end
         end
         checks++;
         if (pulses !== 1 || int'(gq) * dv + int'(gr) != dd || int'(gr) >= dv || int'(gq) != dd / dv) begin
            errors++; $display("FAIL rand5 %0d/%0d got q %0d r %0d pulses %0d want q %0d r %0d", dd, dv, gq, gr, pulses, dd / dv, dd % dv);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_div_zero();
      test_reset_mid();
      test_start_toggle();
      test_back_to_back();
      test_random8(1000);
      test_random5(1000);
      $display("== %0d vectors applied, %0d miscompares ==", checks, errors);
      $finish;
   end

endmodule

// File: doc/restoring_divider.md
# restoring_divider

Sequential unsigned restoring divider, the shift-subtract counterpart of the team's shift-add multiplier. It takes a WIDTH-bit dividend and divisor on a Start pulse and produces quotient and remainder after a fixed number of cycles. It uses the same Start/Ready control style as the multiplier and sits beside it in the arithmetic unit.

## Interface
- WIDTH, 8, operand/result width in bits (≥2)
- Clock  in  1  system clock, rising edge
- Reset  in  1  synchronous, active-low
- Start  in  1  request; sampled only in SLEEP
- Dividend  in  WIDTH  unsigned dividend; sampled in LOAD_DATA
- Divisor  in  WIDTH  unsigned divisor; sampled in LOAD_DATA
- Quotient  out  WIDTH  registered result
- Remainder  out  WIDTH  registered result
- Ready  out  1  one-cycle done pulse
- Busy  out  1  high in LOAD_DATA through CHECK_ZERO
- Div_By_Zero  out  1  registered; valid with Ready; held until next LOAD_DATA

## Operation
- Registers:
  - A: WIDTH+1 bits, partial remainder.
  - Q: WIDTH bits, dividend/quotient.
  - M: WIDTH bits, divisor.
  - P: counter, $clog2(WIDTH+1) bits.
- States: SLEEP, LOAD_DATA, SHIFT, SUBTRACT, RESTORE, CHECK_ZERO, READY.
- SLEEP: Start=1 → LOAD_DATA; else stay.
- LOAD_DATA:
  - Loads A=0, Q=Dividend, M=Divisor, P=WIDTH.
  - Divisor==0 → READY, with Quotient={WIDTH{1}}, Remainder=Dividend, Div_By_Zero=1.
  - Otherwise → SHIFT, with Div_By_Zero=0.
- SHIFT: {A,Q} <<= 1 (A gets Q MSB, Q[0]=0); → SUBTRACT.
- SUBTRACT: A = A − {1'b0,M}, WIDTH+1-bit wraparound; → RESTORE.
- RESTORE:
  - If A[WIDTH]=1: A = A + {1'b0,M} and Q[0]=0.
  - Else: Q[0]=1.
  - Decrement P; → CHECK_ZERO.
- CHECK_ZERO: P==0 → READY; else → SHIFT.
- READY: Quotient=Q, Remainder=A[WIDTH-1:0], Ready=1; → SLEEP.
- Default/illegal state → SLEEP.
- Quotient/Remainder update only on the READY entry edge. They hold from then until the next completion, including through SLEEP and a new operation.
- Start outside SLEEP is ignored. Start held high restarts on the cycle after READY's SLEEP.
- Next-state and Moore outputs use fully-defaulted combinational logic (no latches).

## Timing
- Reset (Reset=0 at a rising edge):
  - State=SLEEP; A, Q, M, P = 0.
  - Quotient=0, Remainder=0, Ready=0, Busy=0, Div_By_Zero=0.
  - Applies mid-operation: the operation is aborted with no Ready pulse.
- Cycle 0 = SLEEP with Start=1.
- Normal path:
  - Cycle 1: LOAD_DATA.
  - Cycles 2..4·WIDTH+1: iterations (4 cycles/bit).
  - Cycle 4·WIDTH+2: READY, with Ready=1. For WIDTH=8 this is cycle 34.
- Divide-by-zero path: READY in cycle 2.
- Ready is high exactly one cycle; Quotient/Remainder/Div_By_Zero are valid in that cycle.
- Operands must be stable during cycle 1 only.
- Busy=0 in SLEEP and READY.

## Structure
- Shared package divider_pkg holds:
  - state localparams (3-bit encoding SLEEP=0 … READY=6)
  - a WIDTH-derived counter-width function
- Natural split:
  - sub-module divider_controller (FSM: Start, A_Neg, Zero, Div0 in; Load_regs, Shift_regs, Sub_regs, Restore_regs, Decr_P, Ready, Busy out)
  - datapath registers in restoring_divider

## Test plan
- 100/7 → Quotient=14, Remainder=2, Ready pulse in cycle 34 only, Busy high cycles 1–33.
- 255/1 → 255,0; 5/9 → 0,5; 200/200 → 1,0; Div_By_Zero=0 throughout.
- 37/0 → Ready cycle 2, Quotient=255, Remainder=37, Div_By_Zero=1; a following 9/3 → 3,0 and Div_By_Zero cleared.
- Reset=0 at cycle 15 of 100/7 → next cycle all outputs 0, state SLEEP, no Ready pulse.
- Start toggling during Busy is ignored. Start held high for 80 cycles on 50/6 → two completions (8,2), Ready in cycles 34 and 69.
- Random 2000 pairs (WIDTH=8 and WIDTH=5) vs. reference / and %: Quotient·Divisor+Remainder==Dividend, Remainder<Divisor.
